blake_round_sequencer: RTL

// - Counterpart to the BLAKE-512 round FSM: consumes its init_round pulse and round_ing level.
// - Generates the per-cycle round/half/G-step indices and the sigma permutation index.
// - Drives count_done back to the FSM on the last step of the last round.
// - Holds a digest_valid/digest_ready handshake toward the finalization/output stage.

---
 rtl/blake_round_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/blake_round_sequencer.sv
// blake_round_sequencer
//   Index sequencer paired with the BLAKE-512 round FSM. It starts on the FSM's
//   init_round pulse and advances one G step per cycle while round_ing is high.
//   It produces round/half/G-step indices and the sigma permutation row, returns
//   count_done on the final step, and then presents digest_valid to the
//   finalization stage until that stage accepts it with digest_ready.
//
// Ports
//   clk, rstb      clock; asynchronous active-low reset
//   init_round     1-cycle start pulse from the round FSM
//   round_ing      high while the round FSM is counting
//   count_done     combinational: last step of the last round
//   step_en        a G step is performed this cycle (= round_ing)
//   round_idx      current round, 0..NUM_ROUNDS-1
//   sigma_idx      permutation row, round_idx mod 10
//   diag           0 = column half-round, 1 = diagonal half-round
//   g_step         G index within the half-round
//   digest_valid   run complete, state ready for finalization
//   digest_ready   consumer accepts the digest
//   busy           run started and not yet complete
//   overrun        (BLAKE_SEQ_OVERRUN_EN only) sticky: a new run discarded an
//                  unaccepted digest; cleared only by rstb
//
// Build option: define BLAKE_SEQ_OVERRUN_EN to add the overrun port.

module blake_round_sequencer #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter int unsigned G_PER_HALF = 4,
    parameter int unsigned GS_W       = 2
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            init_round,
    input  logic            round_ing,
    output logic            count_done,
    output logic            step_en,
    output logic [3:0]      round_idx,
    output logic [3:0]      sigma_idx,
    output logic            diag,
    output logic [GS_W-1:0] g_step,
    output logic            digest_valid,
    input  logic            digest_ready,
    output logic            busy
`ifdef BLAKE_SEQ_OVERRUN_EN
    ,
    output logic            overrun
`endif
);

    localparam logic [3:0]      R_LAST = 4'(NUM_ROUNDS - 1);
    localparam logic [GS_W-1:0] G_LAST = GS_W'(G_PER_HALF - 1);

    logic g_last;

    always_comb begin
        g_last     = (g_step == G_LAST);
        count_done = round_ing & (round_idx == R_LAST) & diag & g_last;
        step_en    = round_ing;
        sigma_idx  = (round_idx >= 4'd10) ? (round_idx - 4'd10) : round_idx;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            round_idx    <= '0;
            diag         <= 1'b0;
            g_step       <= '0;
            busy         <= 1'b0;
            digest_valid <= 1'b0;
        end else if (init_round) begin
            // A new run wins over any concurrent step or handshake, and drops
            // any digest that was never accepted.
            round_idx    <= '0;
            diag         <= 1'b0;
            g_step       <= '0;
            busy         <= 1'b1;
            digest_valid <= 1'b0;
        end else begin
            if (digest_valid && digest_ready) begin
                digest_valid <= 1'b0;
            end
            if (round_ing) begin
                if (count_done) begin
                    // Wrap everything to 0 so indices never overflow.
                    round_idx    <= '0;
                    diag         <= 1'b0;
                    g_step       <= '0;
                    busy         <= 1'b0;
                    digest_valid <= 1'b1;
                end else if (g_last) begin
                    g_step <= '0;
                    diag   <= ~diag;
                    if (diag) begin
                        round_idx <= round_idx + 4'd1;
                    end
                end else begin
                    g_step <= g_step + GS_W'(1);
                end
            end
        end
    end

`ifdef BLAKE_SEQ_OVERRUN_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            overrun <= 1'b0;
        end else if (init_round && digest_valid && !digest_ready) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
